// File: rtl/mem_block_copier.sv
// Block copier: moves `length` bytes from srcAddr to dstAddr through a single
// combinational-read memory port, one READ/WRITE cycle pair per byte.
module mem_block_copier #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] srcAddr,
    input  logic [ADDR_W-1:0] dstAddr,
    input  logic [ADDR_W-1:0] length,
    output logic              busy,
    output logic              done,
    output logic              memWen,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_src_q, cur_src_d;
    logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    // Outputs are registered copies of the decode of the next state, so they
    // still reflect the registered state alone during each cycle.
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_src_d   = cur_src_q;
        cur_dst_d   = cur_dst_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cur_src_d   = srcAddr;
                    cur_dst_d   = dstAddr;
                    remaining_d = length;
                    state_d     = (length == ADDR_W'(0)) ? DONE : READ;
                end
            end
            READ: begin
                hold_d  = memReadData;
                state_d = WRITE;
            end
            WRITE: begin
                cur_src_d   = cur_src_q + ADDR_W'(1);
                cur_dst_d   = cur_dst_q + ADDR_W'(1);
                remaining_d = remaining_q - ADDR_W'(1);
                state_d     = (remaining_q == ADDR_W'(1)) ? DONE : READ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Moore output decode for the state being entered
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        wen_d   = (state_d == WRITE);
        addr_d  = '0;
        wdata_d = '0;
        if (state_d == READ) begin
            addr_d = cur_src_d;
        end else if (state_d == WRITE) begin
            addr_d  = cur_dst_d;
            wdata_d = hold_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign memWen       = wen_q;
    assign memAddress   = addr_q;
    assign memWriteData = wdata_q;

endmodule

// File: doc/mem_block_copier.md
MEM_BLOCK_COPIER -- requirements
Module: mem_block_copier

Interface
REQ-001 Parameter ADDR_W, default 8, sets the address and length width.
REQ-002 Parameter DATA_W, default 8, sets the data byte width.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 start  input  1  copy request, sampled only in IDLE.
REQ-006 srcAddr  input  ADDR_W  first source byte address, latched on accepted start.
REQ-007 dstAddr  input  ADDR_W  first destination byte address, latched on accepted start.
REQ-008 length  input  ADDR_W  byte count, latched on accepted start; 0 = no bytes.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 memWen  output  1  write enable to the data memory port.
REQ-012 memAddress  output  ADDR_W  address to the data memory port.
REQ-013 memWriteData  output  DATA_W  write data to the data memory port.
REQ-014 memReadData  input  DATA_W  combinational read data returned by the data memory for memAddress.

Function
REQ-015 FSM states: IDLE, READ, WRITE, DONE; all outputs decode from registered state only (Moore).
REQ-016 IDLE: start=1 latches srcAddr/dstAddr/length into curSrc/curDst/remaining; next state READ, or DONE if length=0.
REQ-017 start outside IDLE: ignored, no effect on latched registers or sequence.
REQ-018 READ: memAddress=curSrc, memWen=0; memReadData captured into holdReg at cycle end; next state WRITE.
REQ-019 WRITE: memAddress=curDst, memWen=1, memWriteData=holdReg; at cycle end curSrc+1, curDst+1, remaining-1.
REQ-020 WRITE exit: remaining=1 -> DONE, otherwise -> READ.
REQ-021 DONE: done=1, busy=1, memWen=0 for exactly one cycle; next state IDLE.
REQ-022 IDLE outputs: busy=0, done=0, memWen=0, memAddress=0, memWriteData=0.
REQ-023 Address increment wraps modulo 2^ADDR_W (0xFF+1 -> 0x00), independently for source and destination.
REQ-024 Copy order strictly ascending, one byte per READ/WRITE pair; overlapping ranges yield the result of a sequential ascending byte copy, no overlap detection.
REQ-025 Latency: done asserted in the cycle 2*length+1 cycles after the accepting edge (length=0: the cycle immediately after).
REQ-026 memWen asserted exactly length cycles per copy, never in IDLE/READ/DONE.
REQ-027 A new start is accepted in the first IDLE cycle after DONE.

Reset
REQ-028 rst_n=0 at a rising edge forces IDLE and clears curSrc, curDst, remaining, holdReg to 0.
REQ-029 Reset mid-copy: no memWen in the cycle after the reset edge; already written bytes remain, no done pulse for the aborted copy.
REQ-030 start is ignored during any cycle with rst_n=0.

Verification
REQ-031 Preload mem[0x10..0x13]=A1,B2,C3,D4; start src=0x10 dst=0x80 len=4 -> mem[0x80..0x83]=A1,B2,C3,D4; busy high 9 cycles; done pulses 9 cycles after the accepting edge; 4 memWen cycles.
REQ-032 start len=0 -> done pulse the next cycle, busy high 1 cycle, no memWen.
REQ-033 Preload mem[0xFE]=11, mem[0xFF]=22, mem[0x00]=33; src=0xFE dst=0x40 len=3 -> mem[0x40..0x42]=11,22,33; read addresses sequence FE,FF,00.
REQ-034 Preload mem[0x20]=55; src=0x20 dst=0x21 len=3 -> mem[0x21..0x23]=55,55,55.
REQ-035 len=4 copy, rst_n low for one edge right after the second WRITE -> exactly 2 destination bytes written, busy=0, no done; a following len=1 copy completes normally in 3 cycles.
REQ-036 Pulse start with different addresses during READ/WRITE of a len=2 copy -> the original copy completes unchanged; the second request is not executed.
